// File: rtl/uart_rx_sampler.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output register with framing/overrun pulses.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);
    localparam int HALF        = CLKS_PER_BIT / 2;
    localparam int CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int SYNC_STAGES = 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       rx_data_reg;
    logic             rx_valid_reg;
    logic             framing_err_reg;
    logic             overrun_reg;
    logic             busy_reg;

    logic [SYNC_STAGES:0] sync_tap;
    logic                 rxd_s;
    logic                 at_half, at_bit;
    logic                 cnt_clr, shift_en, stop_good, stop_bad;

    // Flops idle high so reset never looks like a start bit.
    assign sync_tap[0] = rxd;
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) stage_reg <= 1'b1;
                else       stage_reg <= sync_tap[gi];
            end
            assign sync_tap[gi+1] = stage_reg;
        end
    endgenerate
    assign rxd_s = sync_tap[SYNC_STAGES];

    assign at_half = (cnt_reg == HALF_LAST);
    assign at_bit  = (cnt_reg == BIT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!rxd_s) state_next = S_START;
            S_START: if (at_half) state_next = rxd_s ? S_IDLE : S_DATA;
            S_DATA:  if (at_bit && bit_idx_reg == 3'd7) state_next = S_STOP;
            S_STOP:  if (at_bit) state_next = rxd_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rxd_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Counter restarts at every sample point so later samples land CLKS_PER_BIT apart.
    always_comb begin
        cnt_clr   = 1'b1;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state_reg)
            S_START: cnt_clr = at_half;
            S_DATA: begin
                cnt_clr  = at_bit;
                shift_en = at_bit;
            end
            S_STOP: begin
                cnt_clr   = at_bit;
                stop_good = at_bit && rxd_s;
                stop_bad  = at_bit && !rxd_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            cnt_reg         <= cnt_clr ? '0 : cnt_reg + CNT_W'(1);
            framing_err_reg <= stop_bad;
            overrun_reg     <= 1'b0;
            busy_reg        <= (state_next != S_IDLE);
            if (shift_en) begin
                shift_reg   <= {rxd_s, shift_reg[7:1]};
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end
            // A delivery coinciding with acceptance replaces the old byte.
            if (stop_good && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
            end else begin
                if (stop_good) overrun_reg <= 1'b1;
                if (rx_valid_reg && rx_ready) rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign framing_err = framing_err_reg;
    assign overrun     = overrun_reg;
    assign busy        = busy_reg;
endmodule

// File: tb/tb_uart_rx_sampler.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_sampler at CLKS_PER_BIT=16: a frame-level model
// predicts each byte/framing/overrun event and its cycle; a monitor checks them.
module tb_uart_rx_sampler;
    localparam int CPB = 16;
    // pin edge -> rxd_s (2) -> mid start bit (HALF) -> stop sample (9 bits) -> register (1)
    localparam int EVENT_LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, framing_err, overrun, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef enum int {EV_BYTE, EV_FERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    logic       slot_full = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;

    uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .nrst(nrst),
        .rxd(rxd),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .framing_err(framing_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic take_event(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s data=0x%02h at cyc %0d, required none", kind.name(), data, cyc);
            return;
        end
        checks--;
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.at);
        if (e.kind == EV_BYTE) begin
            check("event_data", data, e.data);
            hold_data = e.data;
        end
        $display("event %s data=0x%02h cyc=%0d", kind.name(), data, cyc);
    endtask

    // Monitor: a new byte is presented when valid rises or stays high right after an acceptance.
    always @(negedge clk) begin
        if (!nrst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || prev_ready)) take_event(EV_BYTE, rx_data);
            else if (rx_valid) check("held_data", rx_data, hold_data);
            if (framing_err) take_event(EV_FERR, 8'h00);
            if (overrun) take_event(EV_OVR, 8'h00);
            prev_valid = rx_valid;
            prev_ready = rx_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bits(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            tick(CPB);
        end
    endtask

    // Frame-level model: bad stop -> framing error; full slot not being drained -> overrun;
    // otherwise the byte lands and stays until a ready consumer takes it.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic accept_at_stop);
        ev_t e;
        e.at   = cyc + EVENT_LAT;
        e.data = 8'h00;
        if (!stop_bit) e.kind = EV_FERR;
        else if (slot_full && !accept_at_stop) e.kind = EV_OVR;
        else begin
            e.kind    = EV_BYTE;
            e.data    = b;
            slot_full = !rx_ready;
        end
        exp_q.push_back(e);
        $display("send 0x%02h stop=%0d expect %s at cyc %0d", b, stop_bit, e.kind.name(), e.at);
        drive_bits(b, stop_bit);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0;
        logic [7:0] rb;
        logic       stop_ok, rdy;

        tick(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_pulses", {framing_err, overrun}, 2'b00);
        nrst = 1'b1;
        tick(5);
        check("idle_busy", busy, 1'b0);

        // Nominal byte
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b1);
        check("nominal_valid_after", rx_valid, 1'b0);
        check("nominal_busy_after", busy, 1'b0);
        tick(10);

        // Glitch: 4 clocks low
        c0 = cyc;
        rxd = 1'b0;
        tick(3);
        check("glitch_busy_d1", busy, 1'b1);
        tick(1);
        rxd = 1'b1;
        tick(6);
        check("glitch_busy_d8", busy, 1'b1);
        tick(2);
        check("glitch_busy_d10", busy, 1'b0);
        $display("glitch done start=%0d", c0);
        tick(20);

        // Framing error then held-low line, then recovery
        send_frame(8'hA3, 1'b0, 1'b1);
        tick(30);
        check("break_busy", busy, 1'b1);
        tick(34);
        rxd = 1'b1;
        tick(4);
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(10);

        // Overrun
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid_kept", rx_valid, 1'b1);
        rx_ready = 1'b1;
        slot_full = 1'b0;
        tick(1);
        check("ovr_accept_drop", rx_valid, 1'b0);
        tick(5);

        // Acceptance in the stop-sample cycle of the next frame
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                tick(EVENT_LAT - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        check("simul_data", rx_data, 8'h22);
        check("simul_valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        slot_full = 1'b0;
        tick(2);
        check("simul_drained", rx_valid, 1'b0);

        // Reset during data bit 3 with a byte pending
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(4);
        fork
            drive_bits(8'hF0, 1'b1);
            begin
                tick(72);
                check("rst_busy_before", busy, 1'b1);
                check("rst_valid_before", rx_valid, 1'b1);
                #2;
                nrst = 1'b0;
                #1;
                check("rst_async_valid", rx_valid, 1'b0);
                check("rst_async_data", rx_data, 8'h00);
                check("rst_async_busy", busy, 1'b0);
                check("rst_async_pulses", {framing_err, overrun}, 2'b00);
                slot_full = 1'b0;
                tick(16);
                nrst = 1'b1;
            end
        join
        tick(5);
        check("rst_after_busy", busy, 1'b0);
        check("rst_after_valid", rx_valid, 1'b0);
        rx_ready = 1'b1;
        send_frame(8'h7E, 1'b1, 1'b1);
        tick(10);

        // Randomized frames, stop bits and consumer readiness
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rx_ready = rdy;
            if (rdy) slot_full = 1'b0;
            send_frame(rb, stop_ok, rdy);
            if (!stop_ok) begin
                tick($urandom_range(0, 40));
                rxd = 1'b1;
                tick($urandom_range(2, 20));
            end else begin
                tick($urandom_range(0, 20));
            end
        end

        rx_ready = 1'b1;
        slot_full = 1'b0;
        tick(200);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Serial receive front end for the FPGA build. It takes the raw `rxd` pin, synchronises it into the CPU clock domain, and recovers 8N1 UART frames by mid-bit sampling. Received bytes are held in a single-entry output register with a valid/ready handshake, and framing errors and overruns are reported as one-cycle pulses. It sits between the board-level `uart_txd_in` pin and the receive side of the `system` UART, and runs on the divided 50 MHz system clock.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is 4 or more.
- `clk` in 1: system clock (50 MHz in the FPGA build).
- `nrst` in 1: asynchronous, active-low reset. The block uses one clock only.
- `rxd` in 1: raw serial input. It is asynchronous to `clk` and idles high.
- `rx_data` out 8: received byte, valid while `rx_valid`=1.
- `rx_valid` out 1: the output register holds an unconsumed byte.
- `rx_ready` in 1: the consumer accepts the byte on any cycle where `rx_valid`=1 and `rx_ready`=1.
- `framing_err` out 1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped because the output register is still full.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser.** A 2-FF chain drives `rxd_s`. Both flops reset to 1. Every decision uses `rxd_s` only.
- **Constants.** HALF = CLKS_PER_BIT/2, using integer division. A single bit counter is sized with $clog2(CLKS_PER_BIT).
- **States.**
  - IDLE: if `rxd_s`=0, go to START and clear the counter. The cycle in which this happens is the detect cycle D.
  - START: at the sample point D+HALF, if `rxd_s`=0 go to DATA. Otherwise the edge was a glitch; return to IDLE and report no error.
  - DATA: bit k (k=0..7, LSB first) is sampled at D+HALF+(k+1)·CLKS_PER_BIT and shifted into the shift register. After bit 7, go to STOP.
  - STOP: the stop bit is sampled at D+HALF+9·CLKS_PER_BIT.
    - If `rxd_s`=1, deliver the byte and go to IDLE in that same cycle. Sampling mid-stop-bit allows back-to-back frames.
    - If `rxd_s`=0, pulse `framing_err`, discard the byte and go to BREAK.
  - BREAK: wait until `rxd_s`=1, then go to IDLE. A held-low line produces exactly one error.
- **Delivery, in the cycle after the stop sample.**
  - If the register is empty, or `rx_valid`=1 and `rx_ready`=1 in the stop-sample cycle: load `rx_data` and set `rx_valid`. No overrun.
  - Otherwise the new byte is dropped, `overrun` pulses, and `rx_data`/`rx_valid` are unchanged.
- **Handshake.** `rx_valid` clears on the cycle after acceptance. `rx_data` is stable while `rx_valid`=1.
- **Reset.** While `nrst`=0, regardless of activity:
  - state = IDLE, counter = 0, shift register = 0x00;
  - `rx_data`=0x00, `rx_valid`=0, `framing_err`=0, `overrun`=0, `busy`=0;
  - synchroniser flops = 1.
  - A partial frame is discarded. After release, reception resumes only on a new falling edge of `rxd_s`.

## Timing
- Pin to `rxd_s` latency is 2 clocks.
- `busy` rises at D+1 and falls in the cycle after the return to IDLE.
- `rx_valid` rises at D+HALF+9·CLKS_PER_BIT+1.
- `framing_err` and `overrun` are registered pulses lasting exactly 1 cycle.
- With CLKS_PER_BIT=16:
  - stop sample at D+152;
  - `rx_valid` and the overrun/framing decision at D+153;
  - glitch reject at D+8.
- If an acceptance and a new delivery fall on the same cycle, the new byte wins. No byte is lost and no overrun is reported.
- Sample-point tolerance is ±(HALF−1) clocks of cumulative baud mismatch across the frame.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **Nominal byte.** Send 0x55 (8N1) with `rx_ready`=1 → `rx_valid` is high for 1 cycle at D+153 with `rx_data`=0x55; `framing_err`=0 and `overrun`=0; `busy` is low afterwards.
- **Glitch.** Drive `rxd` low for 4 clocks, then high → no `rx_valid` and no error; `busy` returns low by D+10.
- **Framing error.** Send 0xA3 with the stop bit at 0, then hold the line low for 64 clocks → exactly one `framing_err` pulse at D+153 and no `rx_valid`. Then release high and send 0x3C → 0x3C is received cleanly.
- **Overrun.** With `rx_ready`=0, send 0x11 then 0x22 back to back → `rx_valid`=1 holding 0x11; 1 `overrun` pulse at the second delivery; `rx_data` stays 0x11. Then set `rx_ready`=1 → 0x11 is accepted and `rx_valid` drops.
- **Simultaneous accept and deliver.**
  - Hold 0x11 pending, with `rx_ready`=0 until the second frame's stop-sample cycle.
  - Assert `rx_ready`=1 in exactly that cycle while 0x22 completes.
  - Required response: no `overrun`; `rx_data`=0x22 with `rx_valid`=1 on the next cycle.
- **Reset mid-frame.** Assert `nrst`=0 during data bit 3 of 0xF0 → all outputs are 0 immediately. After release, the rest of the old frame yields no byte and no error. A following 0x7E is received correctly.
